// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : button_conditioner                                         |
// | Description : Five-channel pushbutton front end. Each channel has a      |
// |               2-flop synchronizer, a debouncer, a press-pulse generator  |
// |               and an optional auto-repeat engine (IDLE/HOLD/REPEAT).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module button_conditioner #(
  parameter int         DEBOUNCE_CYCLES     = 1000000,
  parameter int         REPEAT_DELAY_CYCLES = 50000000,
  parameter int         REPEAT_RATE_CYCLES  = 10000000,
  parameter logic [4:0] REPEAT_MASK         = 5'b00011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  input  logic       repeat_en,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse
);

  // Bit order on every 5-bit bus: {center, right, left, down, up}
  localparam int c_NUM_BTN = 5;

  // One counter width serves both the debouncer and the repeat engine; the
  // extra bit keeps the terminal compare well clear of any wrap.
  localparam int c_MAX_DB_DLY = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                                DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int c_MAX_CYCLES = (c_MAX_DB_DLY > REPEAT_RATE_CYCLES) ?
                                c_MAX_DB_DLY : REPEAT_RATE_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES) + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_DB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DLY_LAST = c_CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_RPT_LAST = c_CNT_W'(REPEAT_RATE_CYCLES - 1);

  // Auto-repeat state encoding
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_HOLD   = 2'd1;
  localparam logic [1:0] c_ST_REPEAT = 2'd2;

  for (genvar i = 0; i < c_NUM_BTN; i++) begin : g_ch

    logic [1:0]         r_sync;
    logic               w_sync;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic               r_level;
    logic               w_mismatch;
    logic               w_db_done;
    logic               w_level_nxt;
    logic               w_press;
    logic               w_en;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_rpt_cnt;
    logic               w_rpt_fire;
    logic               w_rpt_clr;
    logic               r_pulse;

    // Two-flop synchronizer: the raw pin touches nothing else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= 2'b00;
      end else begin
        r_sync <= {r_sync[0], btn_raw[i]};
      end
    end

    assign w_sync      = r_sync[1];
    assign w_mismatch  = w_sync ^ r_level;
    // Accept a change once the mismatch has lasted DEBOUNCE_CYCLES cycles
    assign w_db_done   = w_mismatch && (r_db_cnt == c_DB_LAST);
    assign w_level_nxt = r_level ^ w_db_done;
    // Press is the 0->1 acceptance; release never produces a pulse
    assign w_press     = w_db_done && !r_level;
    assign w_en        = repeat_en & REPEAT_MASK[i];

    // Debounce counter: runs while the input disagrees, clears otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db_cnt <= c_CNT_ZERO;
      end else if (!w_mismatch || w_db_done) begin
        r_db_cnt <= c_CNT_ZERO;
      end else begin
        r_db_cnt <= r_db_cnt + c_CNT_ONE;
      end
    end

    // Debounced level register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_level <= 1'b0;
      end else begin
        r_level <= w_level_nxt;
      end
    end

    // Repeat FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= c_ST_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // Repeat FSM next state; exits look at the level being written this edge
    // so a release never coincides with a final repeat pulse
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        c_ST_IDLE: begin
          if (w_press && w_en) begin
            w_state_nxt = c_ST_HOLD;
          end
        end
        c_ST_HOLD: begin
          if (!w_level_nxt || !w_en) begin
            w_state_nxt = c_ST_IDLE;
          end else if (r_rpt_cnt == c_DLY_LAST) begin
            w_state_nxt = c_ST_REPEAT;
          end
        end
        c_ST_REPEAT: begin
          if (!w_level_nxt || !w_en) begin
            w_state_nxt = c_ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = c_ST_IDLE;
        end
      endcase
    end

    // Repeat FSM outputs: repeat-pulse request and counter control
    always_comb begin
      w_rpt_fire = 1'b0;
      w_rpt_clr  = 1'b1;
      case (r_state)
        c_ST_HOLD: begin
          if (w_level_nxt && w_en) begin
            if (r_rpt_cnt == c_DLY_LAST) begin
              w_rpt_fire = 1'b1;
            end else begin
              w_rpt_clr = 1'b0;
            end
          end
        end
        c_ST_REPEAT: begin
          if (w_level_nxt && w_en) begin
            if (r_rpt_cnt == c_RPT_LAST) begin
              w_rpt_fire = 1'b1;
            end else begin
              w_rpt_clr = 1'b0;
            end
          end
        end
        default: begin
          w_rpt_fire = 1'b0;
          w_rpt_clr  = 1'b1;
        end
      endcase
    end

    // Repeat counter: counts from the press-pulse edge, restarts per pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rpt_cnt <= c_CNT_ZERO;
      end else if (w_rpt_clr) begin
        r_rpt_cnt <= c_CNT_ZERO;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + c_CNT_ONE;
      end
    end

    // Pulse register: press and repeat are mutually exclusive by construction
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_press | w_rpt_fire;
      end
    end

    assign btn_level[i] = r_level;
    assign btn_pulse[i] = r_pulse;

  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_button_conditioner                                      |
// | Description : Directed self-checking bench for button_conditioner with   |
// |               DEBOUNCE=8, DELAY=40, RATE=10. Cycle k is the state seen   |
// |               after the k-th rising edge following the stimulus change.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic       repeat_en;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  int n_err;
  int n_chk;

  button_conditioner #(
    .DEBOUNCE_CYCLES    (8),
    .REPEAT_DELAY_CYCLES(40),
    .REPEAT_RATE_CYCLES (10),
    .REPEAT_MASK        (5'b00011)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle at the falling edge for sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset with all inputs idle; release lands on a falling edge
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    btn_raw   = 5'b0;
    repeat_en = 1'b0;
    #1;
    check_val("reset_async", {btn_level, btn_pulse}, 32'h0);
    repeat (3) @(negedge clk);
    check_val("reset_hold", {btn_level, btn_pulse}, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] acc;
    n_err     = 0;
    n_chk     = 0;
    rst_n     = 1'b0;
    btn_raw   = 5'b0;
    repeat_en = 1'b0;

    // Up held 20 cycles: level 10..29, single pulse at 10, none on release
    do_reset();
    btn_raw = 5'b00001;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_val($sformatf("up_pulse@%0d", k), btn_pulse, (k == 10) ? 5'b00001 : 5'b0);
      check_val($sformatf("up_level@%0d", k), btn_level,
                (k >= 10 && k < 30) ? 5'b00001 : 5'b0);
      if (k == 20) btn_raw = 5'b0;
    end

    // Left toggling every 3 cycles: never accepted
    do_reset();
    acc = '0;
    btn_raw = 5'b00100;
    for (int k = 1; k <= 70; k++) begin
      step();
      acc |= {btn_level, btn_pulse};
      if (k < 60) btn_raw[2] = ((k / 3) % 2 == 0);
      else        btn_raw[2] = 1'b0;
    end
    check_val("glitch_quiet", acc, 32'h0);

    // Down held 100 cycles with repeat: 10, 50, 60 .. 100, nothing after
    do_reset();
    btn_raw   = 5'b00010;
    repeat_en = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      step();
      check_val($sformatf("down_pulse@%0d", k), btn_pulse,
                (k == 10 || (k >= 50 && k <= 100 && k % 10 == 0)) ? 5'b00010 : 5'b0);
      check_val($sformatf("down_level@%0d", k), btn_level,
                (k >= 10 && k < 110) ? 5'b00010 : 5'b0);
      if (k == 100) btn_raw = 5'b0;
    end

    // Center held 100 cycles: masked from repeat, single pulse at 10
    do_reset();
    btn_raw   = 5'b10000;
    repeat_en = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      step();
      check_val($sformatf("center_pulse@%0d", k), btn_pulse, (k == 10) ? 5'b10000 : 5'b0);
      if (k == 100) btn_raw = 5'b0;
    end

    // Up+down together; repeat_en dropped at 55 stops repeats before 60
    do_reset();
    btn_raw   = 5'b00011;
    repeat_en = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      step();
      check_val($sformatf("dual_pulse@%0d", k), btn_pulse,
                (k == 10 || k == 50) ? 5'b00011 : 5'b0);
      check_val($sformatf("dual_level@%0d", k), btn_level,
                (k >= 10 && k < 110) ? 5'b00011 : 5'b0);
      if (k == 55)  repeat_en = 1'b0;
      if (k == 100) btn_raw = 5'b0;
    end

    // Reset at 45 while up is held in HOLD; re-press counted from release
    do_reset();
    btn_raw   = 5'b00001;
    repeat_en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      check_val($sformatf("rst_pre_pulse@%0d", k), btn_pulse, (k == 10) ? 5'b00001 : 5'b0);
    end
    check_val("rst_pre_level", btn_level, 5'b00001);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_async", {btn_level, btn_pulse}, 32'h0);
    step();
    step();
    check_val("rst_mid_hold", {btn_level, btn_pulse}, 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check_val($sformatf("rst_post_pulse@%0d", k), btn_pulse, (k == 10) ? 5'b00001 : 5'b0);
      check_val($sformatf("rst_post_level@%0d", k), btn_level, (k >= 10) ? 5'b00001 : 5'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
